// File: rtl/fpadd_rr_arbiter.sv
// Round-robin arbiter sharing one start/done FP adder among NUM_REQ clients, with a WAIT watchdog.
// Optional FPADD_ARB_STATS_EN adds saturating op_count / timeout_count outputs.
module fpadd_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_result,
   output logic                   fpa_start,
   output logic [31:0]            fpa_a,
   output logic [31:0]            fpa_b,
   input  logic [31:0]            fpa_result,
   input  logic                   fpa_done,
   output logic                   busy,
   output logic                   timeout_err
`ifdef FPADD_ARB_STATS_EN
   ,
   output logic [15:0]            op_count,
   output logic [7:0]             timeout_count
`endif
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              state_q;
   logic [IW-1:0]       last_q, idx_q;
   logic [CW-1:0]       cnt_q;
   logic                to_q;
   logic [NUM_REQ-1:0]  gnt_q, rsp_valid_q;
   logic [31:0]         rsp_result_q, fpa_a_q, fpa_b_q;
   logic                fpa_start_q, busy_q, timeout_err_q;

   logic [IW-1:0]       pick_d;
   logic                pick_vld;

   // First requester after the last served one, wrapping modulo NUM_REQ.
   always_comb begin
      int j;
      logic [IW-1:0] jj;
      pick_d   = '0;
      pick_vld = 1'b0;
      j        = 0;
      jj       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j  = (int'(last_q) + k) % NUM_REQ;
         jj = IW'(j);
         if (!pick_vld && req[jj]) begin
            pick_vld = 1'b1;
            pick_d   = jj;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         last_q        <= IW'(NUM_REQ - 1);
         idx_q         <= '0;
         cnt_q         <= '0;
         to_q          <= 1'b0;
         gnt_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_result_q  <= '0;
         fpa_a_q       <= '0;
         fpa_b_q       <= '0;
         fpa_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_vld) begin
                  idx_q         <= pick_d;
                  fpa_a_q       <= req_a[32*int'(pick_d) +: 32];
                  fpa_b_q       <= req_b[32*int'(pick_d) +: 32];
                  gnt_q         <= '0;
                  gnt_q[pick_d] <= 1'b1;
                  fpa_start_q   <= 1'b1;
                  busy_q        <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               gnt_q       <= '0;
               fpa_start_q <= 1'b0;
               cnt_q       <= '0;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 1'b1;
               // done has priority over a coincident watchdog expiry
               if (fpa_done) begin
                  rsp_result_q       <= fpa_result;
                  rsp_valid_q[idx_q] <= 1'b1;
                  to_q               <= 1'b0;
                  state_q            <= S_RESP;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  rsp_result_q       <= QNAN;
                  rsp_valid_q[idx_q] <= 1'b1;
                  to_q               <= 1'b1;
                  timeout_err_q      <= 1'b1;
                  state_q            <= S_RESP;
               end
            end
            default: begin
               rsp_valid_q <= '0;
               last_q      <= idx_q;
               cnt_q       <= '0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign fpa_start   = fpa_start_q;
   assign fpa_a       = fpa_a_q;
   assign fpa_b       = fpa_b_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

`ifdef FPADD_ARB_STATS_EN
   logic [15:0] op_cnt_q;
   logic [7:0]  to_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt_q <= '0;
         to_cnt_q <= '0;
      end else if (state_q == S_RESP) begin
         if (!to_q && op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
         if (to_q && to_cnt_q != 8'hFF)     to_cnt_q <= to_cnt_q + 8'd1;
      end
   end

   assign op_count      = op_cnt_q;
   assign timeout_count = to_cnt_q;
`endif
endmodule
